// File: rtl/alu_exec_if.sv
// Request/result bundle between the operand stage, the ALU execution unit and writeback.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both high.
interface alu_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_i;
  logic                  ready_o;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] ALU_Result_o;
  logic                  Zero_o;
  logic                  Illegal_o;
  logic [1:0]            state_dbg;

  modport master (
    output valid_i, ALU_Operation_i, A_i, B_i, ready_i,
    input  ready_o, valid_o, ALU_Result_o, Zero_o, Illegal_o, state_dbg
  );

  modport slave (
    input  valid_i, ALU_Operation_i, A_i, B_i, ready_i,
    output ready_o, valid_o, ALU_Result_o, Zero_o, Illegal_o, state_dbg
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: ADD/SUB/OR in one execute cycle, SLL as a 1-bit-per-cycle shifter,
// valid/ready on both the request and the result side.
module alu_exec_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input logic       clk,
  input logic       reset,
  alu_exec_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  work_q;
  logic [DATA_WIDTH-1:0]  result_q;
  logic [DATA_WIDTH-1:0]  exec_res;
  logic [DATA_WIDTH-1:0]  work_shl;
  logic [DATA_WIDTH-1:0]  final_res;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   shift_en_q;
  logic                   zero_q;
  logic                   illegal_q;
  logic                   legal;
  logic                   is_sll;
  logic                   accept;
  logic                   do_shift;

  assign shamt     = bus.B_i[SHAMT_WIDTH-1:0];
  assign accept    = bus.valid_i && (state_q == IDLE);
  assign do_shift  = is_sll && (shamt != '0);
  assign work_shl  = {work_q[DATA_WIDTH-2:0], 1'b0};
  assign final_res = shift_en_q ? work_shl : work_q;

  always_comb begin
    legal    = 1'b1;
    is_sll   = 1'b0;
    exec_res = '0;
    case (bus.ALU_Operation_i)
      OP_ADD:  exec_res = bus.A_i + bus.B_i;
      OP_SUB:  exec_res = bus.A_i - bus.B_i;
      OP_OR:   exec_res = bus.A_i | bus.B_i;
      OP_SLL: begin
        is_sll   = 1'b1;
        exec_res = bus.A_i;
      end
      default: legal = 1'b0;
    endcase
  end

  // Every accepted op passes through SHIFT: non-shifting ops use one pass-through cycle
  // with the count at 1, so single-cycle ops and one-step shifts share the same latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == SHAMT_WIDTH'(1)) state_d = DONE;
      DONE:    if (bus.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_q     <= '0;
      cnt_q      <= '0;
      shift_en_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      work_q     <= exec_res;
      shift_en_q <= do_shift;
      cnt_q      <= do_shift ? shamt : SHAMT_WIDTH'(1);
      illegal_q  <= !legal;
    end else if (state_q == SHIFT) begin
      if (shift_en_q) work_q <= work_shl;
      cnt_q <= cnt_q - SHAMT_WIDTH'(1);
      if (cnt_q == SHAMT_WIDTH'(1)) begin
        result_q <= final_res;
        zero_q   <= (final_res == '0);
      end
    end
  end

  assign bus.ready_o      = (state_q == IDLE);
  assign bus.valid_o      = (state_q == DONE);
  assign bus.ALU_Result_o = result_q;
  assign bus.Zero_o       = zero_q;
  assign bus.Illegal_o    = illegal_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expected results.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_q[$];

  alu_exec_if #(.DATA_WIDTH(32)) bus ();

  alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, then count clock edges from the accept edge until valid_o.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk);
    check("ready_before_issue", {31'b0, bus.ready_o}, 32'd1);
    bus.ALU_Operation_i = op;
    bus.A_i             = a;
    bus.B_i             = b;
    bus.valid_i         = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    lat = 0;
    while (lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.valid_o) break;
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                       input logic exp_ill, input int exp_lat);
    int lat;
    exp_q.push_back(exp_r);
    issue(op, a, b, lat);
    check({tag, "_lat"},     lat, exp_lat);
    check({tag, "_valid"},   {31'b0, bus.valid_o}, 32'd1);
    check({tag, "_result"},  bus.ALU_Result_o, exp_q.pop_front());
    check({tag, "_zero"},    {31'b0, bus.Zero_o}, {31'b0, exp_z});
    check({tag, "_illegal"}, {31'b0, bus.Illegal_o}, {31'b0, exp_ill});
    check({tag, "_ready_lo"}, {31'b0, bus.ready_o}, 32'd0);
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1 bus.ready_i = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, {31'b0, bus.valid_o}, 32'd0);
    check({tag, "_ready_hi"},   {31'b0, bus.ready_o}, 32'd1);
  endtask

  initial begin
    int lat;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.ALU_Operation_i = 4'b0000;
    bus.A_i = 32'd0;
    bus.B_i = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_valid",   {31'b0, bus.valid_o}, 32'd0);
    check("rst_result",  bus.ALU_Result_o, 32'd0);
    check("rst_zero",    {31'b0, bus.Zero_o}, 32'd0);
    check("rst_illegal", {31'b0, bus.Illegal_o}, 32'd0);
    rst_n = 1'b1;
    #1 check("rst_ready", {31'b0, bus.ready_o}, 32'd1);

    do_op("add_5_7",   4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1);
    do_op("sub_9_9",   4'b0001, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1);
    do_op("sub_wrap",  4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    do_op("or",        4'b0010, 32'h0F0F_0000, 32'h00F0_00FF, 32'h0FFF_00FF, 1'b0, 1'b0, 1);
    do_op("illegal",   4'b1000, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 1);
    do_op("add_1_1",   4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);
    do_op("sll_0",     4'b0100, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0, 1);
    do_op("sll_1",     4'b0100, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);
    do_op("sll_31",    4'b0100, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 31);
    do_op("sll_field", 4'b0100, 32'd1, 32'hFFFF_FFE3, 32'd8, 1'b0, 1'b0, 3);

    // result taken the same cycle it appears
    bus.ready_i = 1'b1;
    issue(4'b0000, 32'd10, 32'd20, lat);
    check("rdy_entry_lat",    lat, 32'd1);
    check("rdy_entry_result", bus.ALU_Result_o, 32'd30);
    @(negedge clk);
    check("rdy_entry_1cyc", {31'b0, bus.valid_o}, 32'd0);
    bus.ready_i = 1'b0;
    check("rdy_entry_idle", {31'b0, bus.ready_o}, 32'd1);

    // backpressure with a stray request in the middle of the hold
    issue(4'b0000, 32'd3, 32'd4, lat);
    check("bp_lat", lat, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.ALU_Operation_i = 4'b0000;
        bus.A_i = 32'd100;
        bus.B_i = 32'd100;
        bus.valid_i = 1'b1;
      end
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      @(negedge clk);
      check("bp_valid",  {31'b0, bus.valid_o}, 32'd1);
      check("bp_result", bus.ALU_Result_o, 32'd7);
      check("bp_ready",  {31'b0, bus.ready_o}, 32'd0);
    end
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1 bus.ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp_no_accept_ready", {31'b0, bus.ready_o}, 32'd1);
    check("bp_no_accept_valid", {31'b0, bus.valid_o}, 32'd0);

    // reset in the middle of a 20-step shift
    @(negedge clk);
    bus.ALU_Operation_i = 4'b0100;
    bus.A_i = 32'd1;
    bus.B_i = 32'd20;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid",  {31'b0, bus.valid_o}, 32'd0);
    check("midrst_result", bus.ALU_Result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_ready", {31'b0, bus.ready_o}, 32'd1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("midrst_no_result", {31'b0, bus.valid_o}, 32'd0);
    do_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
